// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and 16-bit instruction fetch into the IF/ID register, with skid buffer and redirect flush.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt/flush_cnt performance counters.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_cond,
    input  logic [15:0] pc_out_br,
    input  logic        id_stall,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus_2,
    output logic        if_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] fetch_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic        halted
);
    typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;
    localparam logic [15:0] NOP = 16'h0800;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d, redir_q, redir_d;
    logic [15:0] if_instr_q, if_instr_d, if_pc2_q, if_pc2_d;
    logic [15:0] skid_instr_q, skid_instr_d, skid_pc2_q, skid_pc2_d;
    logic        imem_rd_q, imem_rd_d, if_valid_q, if_valid_d;
    logic        skid_valid_q, skid_valid_d, halted_q, halted_d;
    logic        accept, deliver, load_ifid, pending;
    logic [15:0] pc_plus_2;

    assign accept    = imem_rd_q && imem_ready;
    assign pending   = imem_rd_q && !imem_ready;
    assign pc_plus_2 = pc_q + 16'd2;
    assign deliver   = accept && state_q == FETCH && !branch_cond;
    assign load_ifid = !branch_cond && !id_stall && (skid_valid_q || deliver);

    assign imem_rd      = imem_rd_q;
    assign imem_addr    = pc_q;
    assign if_instr     = if_instr_q;
    assign if_pc_plus_2 = if_pc2_q;
    assign if_valid     = if_valid_q;
    assign halted       = halted_q;

    // Next-state: redirect first, then FSM request control, then IF/ID / skid movement.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_d      = redir_q;
        imem_rd_d    = imem_rd_q;
        if_instr_d   = if_instr_q;
        if_pc2_d     = if_pc2_q;
        if_valid_d   = if_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc2_d   = skid_pc2_q;
        skid_valid_d = skid_valid_q;
        halted_d     = halted_q;
        if (branch_cond) begin
            if_valid_d   = 1'b0;
            if_instr_d   = NOP;
            skid_valid_d = 1'b0;
            halted_d     = 1'b0;
            redir_d      = pc_out_br;
            state_d      = pending ? DRAIN : FETCH;
            imem_rd_d    = pending;
            pc_d         = pending ? pc_q : pc_out_br;
        end else begin
            case (state_q)
                FETCH: begin
                    if (accept) begin
                        pc_d      = pc_plus_2;
                        imem_rd_d = 1'b0;
                        if (imem_data[15:11] == HALT_OPCODE) begin
                            state_d  = HALT;
                            halted_d = 1'b1;
                        end
                    end else if (!imem_rd_q) begin
                        imem_rd_d = !skid_valid_q;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        pc_d      = redir_q;
                        imem_rd_d = 1'b0;
                        state_d   = FETCH;
                    end
                end
                default: imem_rd_d = 1'b0;
            endcase
            if (!id_stall) begin
                if (skid_valid_q) begin
                    if_instr_d   = skid_instr_q;
                    if_pc2_d     = skid_pc2_q;
                    skid_valid_d = 1'b0;
                end else if (deliver) begin
                    if_instr_d = imem_data;
                    if_pc2_d   = pc_plus_2;
                end
                if_valid_d = skid_valid_q || deliver;
            end else if (deliver) begin
                skid_instr_d = imem_data;
                skid_pc2_d   = pc_plus_2;
                skid_valid_d = 1'b1;
            end
        end
    end

    // State and pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            redir_q      <= RESET_PC;
            imem_rd_q    <= 1'b0;
            if_instr_q   <= NOP;
            if_pc2_q     <= 16'h0000;
            if_valid_q   <= 1'b0;
            skid_instr_q <= NOP;
            skid_pc2_q   <= 16'h0000;
            skid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_q      <= redir_d;
            imem_rd_q    <= imem_rd_d;
            if_instr_q   <= if_instr_d;
            if_pc2_q     <= if_pc2_d;
            if_valid_q   <= if_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc2_q   <= skid_pc2_d;
            skid_valid_q <= skid_valid_d;
            halted_q     <= halted_d;
        end
    end

    // A capture while stalled with a full skid would lose an instruction; requests are gated to prevent it.
    assert property (@(posedge clk) disable iff (!rst_n) !(deliver && id_stall && skid_valid_q));

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Saturating counts of IF/ID loads and redirects.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 16'(load_ifid && fetch_cnt_q != 16'hFFFF);
        flush_cnt_d = flush_cnt_q + 16'(branch_cond && flush_cnt_q != 16'hFFFF);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
`else
    logic unused_load;
    assign unused_load = load_ifid;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed cycle-by-cycle expectations.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_cond;
    logic [15:0] pc_out_br;
    logic        id_stall;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic [15:0] if_instr;
    logic [15:0] if_pc_plus_2;
    logic        if_valid;
    logic        halted;
    logic        rdy_en;
    int          n_cmp = 0;
    int          n_err = 0;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    // Memory model: word at byte address a is 0x4000 + a/2, except a HALT (0x0000) at 0x0010.
    assign imem_ready = imem_rd && rdy_en;
    assign imem_data  = (imem_addr == 16'h0010) ? 16'h0000 : 16'h4000 + (imem_addr >> 1);

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .branch_cond(branch_cond), .pc_out_br(pc_out_br),
        .id_stall(id_stall), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data), .if_instr(if_instr),
        .if_pc_plus_2(if_pc_plus_2), .if_valid(if_valid),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt),
`endif
        .halted(halted)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; branch_cond = 1'b0; pc_out_br = 16'h0000; id_stall = 1'b0; rdy_en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rd", {15'd0, imem_rd}, 16'd0);
        chk("rst_valid", {15'd0, if_valid}, 16'd0);
        chk("rst_instr", if_instr, 16'h0800);
        chk("rst_pc2", if_pc_plus_2, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        rst_n = 1'b1;
        // zero-wait stream
        tick(); chk("t1_rd0", {15'd0, imem_rd}, 16'd1); chk("t1_addr0", imem_addr, 16'h0000);
        tick(); chk("t1_instr0", if_instr, 16'h4000); chk("t1_pc2_0", if_pc_plus_2, 16'h0002);
        chk("t1_valid0", {15'd0, if_valid}, 16'd1); chk("t1_rd_gap", {15'd0, imem_rd}, 16'd0);
        tick(); chk("t1_addr2", imem_addr, 16'h0002); chk("t1_valid_drain", {15'd0, if_valid}, 16'd0);
        tick(); chk("t1_instr1", if_instr, 16'h4001); chk("t1_pc2_1", if_pc_plus_2, 16'h0004);
        tick(); chk("t1_addr4", imem_addr, 16'h0004);
        tick(); chk("t1_instr2", if_instr, 16'h4002); chk("t1_pc2_2", if_pc_plus_2, 16'h0006);
        // wait states
        rdy_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_rd_hold", {15'd0, imem_rd}, 16'd1);
            chk("t2_addr_hold", imem_addr, 16'h0006);
            chk("t2_valid_low", {15'd0, if_valid}, 16'd0);
        end
        rdy_en = 1'b1;
        tick(); chk("t2_instr", if_instr, 16'h4003); chk("t2_pc2", if_pc_plus_2, 16'h0008);
        chk("t2_valid", {15'd0, if_valid}, 16'd1);
        // stall into skid
        id_stall = 1'b1;
        tick(); chk("t3_rd", {15'd0, imem_rd}, 16'd1); chk("t3_hold_instr0", if_instr, 16'h4003);
        tick(); chk("t3_hold_instr", if_instr, 16'h4003); chk("t3_hold_pc2", if_pc_plus_2, 16'h0008);
        chk("t3_rd_gap", {15'd0, imem_rd}, 16'd0);
        tick(); chk("t3_no_req_full", {15'd0, imem_rd}, 16'd0); chk("t3_hold_valid", {15'd0, if_valid}, 16'd1);
        id_stall = 1'b0;
        tick(); chk("t3_skid_instr", if_instr, 16'h4004); chk("t3_skid_pc2", if_pc_plus_2, 16'h000A);
        chk("t3_skid_valid", {15'd0, if_valid}, 16'd1);
        tick(); chk("t3_rereq", {15'd0, imem_rd}, 16'd1); chk("t3_addr", imem_addr, 16'h000A);
        // redirect while pending -> drain
        rdy_en = 1'b0; branch_cond = 1'b1; pc_out_br = 16'h0100;
        tick(); chk("t4_drain_rd", {15'd0, imem_rd}, 16'd1); chk("t4_drain_addr", imem_addr, 16'h000A);
        chk("t4_flush_valid", {15'd0, if_valid}, 16'd0); chk("t4_flush_nop", if_instr, 16'h0800);
        branch_cond = 1'b0; rdy_en = 1'b1;
        tick(); chk("t4_drop_valid", {15'd0, if_valid}, 16'd0); chk("t4_drop_instr", if_instr, 16'h0800);
        chk("t4_new_addr", imem_addr, 16'h0100);
        tick(); chk("t4_req", {15'd0, imem_rd}, 16'd1);
        tick(); chk("t4_instr", if_instr, 16'h4080); chk("t4_pc2", if_pc_plus_2, 16'h0102);
        // redirect coinciding with ready
        tick(); chk("t4b_req", imem_addr, 16'h0102);
        branch_cond = 1'b1; pc_out_br = 16'h0010;
        tick(); chk("t4b_valid", {15'd0, if_valid}, 16'd0); chk("t4b_instr", if_instr, 16'h0800);
        chk("t4b_addr", imem_addr, 16'h0010); chk("t4b_rd", {15'd0, imem_rd}, 16'd0);
        branch_cond = 1'b0;
        // halt and resume
        tick(); chk("t5_req", {15'd0, imem_rd}, 16'd1);
        tick(); chk("t5_instr", if_instr, 16'h0000); chk("t5_pc2", if_pc_plus_2, 16'h0012);
        chk("t5_valid", {15'd0, if_valid}, 16'd1); chk("t5_halted", {15'd0, halted}, 16'd1);
        chk("t5_rd", {15'd0, imem_rd}, 16'd0);
        tick(); chk("t5_halted2", {15'd0, halted}, 16'd1); chk("t5_rd2", {15'd0, imem_rd}, 16'd0);
        tick(); chk("t5_rd3", {15'd0, imem_rd}, 16'd0);
        branch_cond = 1'b1; pc_out_br = 16'h0020;
        tick(); chk("t5_unhalt", {15'd0, halted}, 16'd0); chk("t5_addr", imem_addr, 16'h0020);
        branch_cond = 1'b0;
        tick(); chk("t5_resume", {15'd0, imem_rd}, 16'd1); chk("t5_resume_addr", imem_addr, 16'h0020);
        tick(); chk("t5_res_instr", if_instr, 16'h4010); chk("t5_res_pc2", if_pc_plus_2, 16'h0022);
        // async reset mid-request
        branch_cond = 1'b1; pc_out_br = 16'h0044; rdy_en = 1'b0;
        tick(); chk("t6_addr", imem_addr, 16'h0044);
        branch_cond = 1'b0;
        tick(); chk("t6_req", {15'd0, imem_rd}, 16'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", fetch_cnt, 16'd8);
        chk("perf_flush", flush_cnt, 16'd4);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rd", {15'd0, imem_rd}, 16'd0);
        chk("t6_addr_rst", imem_addr, 16'h0000);
        chk("t6_valid", {15'd0, if_valid}, 16'd0);
        chk("t6_instr", if_instr, 16'h0800);
        chk("t6_pc2", if_pc_plus_2, 16'h0000);
        chk("t6_halted", {15'd0, halted}, 16'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_rst", fetch_cnt | flush_cnt, 16'd0);
`endif
        #1 rst_n = 1'b1; rdy_en = 1'b1;
        tick(); chk("t6_first_req", {15'd0, imem_rd}, 16'd1); chk("t6_first_addr", imem_addr, 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
